// File: rtl/vthernet_pkg.sv
// Shared Vthernet constants: GMII framing octets, CRC-32 parameters and RX FSM encoding.
package vthernet_pkg;
    localparam logic [7:0]  PRE             = 8'b10101010;
    localparam logic [7:0]  SFD             = 8'b10101011;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [47:0] BCAST_MAC       = 48'hFFFFFFFFFFFF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_DROP     = 3'd3;
    localparam logic [2:0] ST_COMMIT   = 3'd4;
endpackage

// File: rtl/vthernet_crc32_byte.sv
// Combinational reflected CRC-32 update for one octet, LSB first.
module vthernet_crc32_byte
    import vthernet_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/vthernet_rx_mac_mf.sv
// GMII receive MAC with address/type filtering, FCS check and a ring of frame slots.
// state     | meaning
// IDLE      | waiting for preamble
// PREAMBLE  | inside preamble, waiting for SFD
// DATA      | storing frame bytes DA..FCS
// DROP      | discarding rest of frame until RX_DV falls
// COMMIT    | publishing the finished frame into its slot
module vthernet_rx_mac_mf
    import vthernet_pkg::*;
#(
    parameter int N_MAC      = 4,
    parameter int N_SLOTS    = 4,
    parameter int SLOT_BYTES = 2048,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int ADDR_W     = 32,
    localparam int SLOT_W    = $clog2(N_SLOTS)
) (
    input  logic                RX_CLK,
    input  logic                rst_n,
    input  logic [48*N_MAC-1:0] my_mac_addr,
    input  logic [N_MAC-1:0]    mac_en,
    input  logic                promisc,
    input  logic                accept_bcast,
    input  logic [15:0]         ethernet_len_type,
    input  logic                len_type_en,
    input  logic [ADDR_W-1:0]   rx_base_addr,
    input  logic                RX_DV,
    input  logic                RX_ER,
    input  logic [7:0]          RXD,
    input  logic                rx_slot_release,
    output logic [47:0]         dst_mac_addr,
    output logic [47:0]         src_mac_addr,
    output logic [15:0]         rx_len_type,
    output logic [15:0]         rx_frame_len,
    output logic [SLOT_W-1:0]   rx_slot_idx,
    output logic                rx_irq,
    output logic [15:0]         rx_drop_cnt,
    output logic                rx_mem_wen,
    output logic [7:0]          rx_mem_data,
    output logic [ADDR_W-1:0]   rx_mem_addr
);
    localparam int               SLOT_SH    = $clog2(SLOT_BYTES);
    localparam logic [SLOT_W:0]  PEND_FULL  = (SLOT_W+1)'(N_SLOTS);
    localparam logic [SLOT_W:0]  PEND_ONE   = (SLOT_W+1)'(1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    logic [2:0]        state, state_next;
    logic [15:0]       byte_idx;
    logic [31:0]       crc, crc_next;
    logic [47:0]       cur_da, cur_sa, da_full;
    logic [15:0]       cur_lt, lt_full;
    logic [SLOT_W-1:0] wr_slot, rd_slot;
    logic [SLOT_W:0]   pending, pending_next;
    logic              da_hit, drop_inc, do_commit, do_release;
    logic [ADDR_W-1:0] wr_addr;

    logic [47:0] slot_da  [N_SLOTS];
    logic [47:0] slot_sa  [N_SLOTS];
    logic [15:0] slot_lt  [N_SLOTS];
    logic [15:0] slot_len [N_SLOTS];

    vthernet_crc32_byte u_crc (
        .crc_in  (crc),
        .data    (RXD),
        .crc_out (crc_next)
    );

    // DA/type are judged on the cycle their last octet is on RXD
    assign da_full = {cur_da[39:0], RXD};
    assign lt_full = {cur_lt[7:0], RXD};
    assign wr_addr = rx_base_addr + (ADDR_W'(wr_slot) << SLOT_SH) + ADDR_W'(byte_idx);

    always_comb begin
        da_hit = promisc || (accept_bcast && da_full == BCAST_MAC);
        for (int i = 0; i < N_MAC; i++) begin
            if (mac_en[i] && da_full == my_mac_addr[48*i +: 48]) da_hit = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        drop_inc   = 1'b0;
        case (state)
            ST_IDLE: if (RX_DV && RXD == PRE) state_next = ST_PREAMBLE;
            ST_PREAMBLE: begin
                if (!RX_DV) state_next = ST_IDLE;
                else if (RXD == SFD) begin
                    if (pending < PEND_FULL) state_next = ST_DATA;
                    else begin
                        state_next = ST_DROP;
                        drop_inc   = 1'b1;
                    end
                end else if (RXD != PRE) state_next = ST_DROP;
            end
            ST_DATA: begin
                if (!RX_DV) begin
                    if (byte_idx < 16'(MIN_LEN) || crc != CRC32_RESIDUE) begin
                        state_next = ST_IDLE;
                        drop_inc   = 1'b1;
                    end else state_next = ST_COMMIT;
                end else if (RX_ER || byte_idx == 16'(MAX_LEN)) begin
                    state_next = ST_DROP;
                    drop_inc   = 1'b1;
                end else if (byte_idx == 16'd5 && !da_hit) state_next = ST_DROP;
                else if (byte_idx == 16'd13 && len_type_en && lt_full != ethernet_len_type)
                    state_next = ST_DROP;
            end
            ST_DROP:   if (!RX_DV) state_next = ST_IDLE;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign do_commit  = (state == ST_COMMIT);
    assign do_release = rx_slot_release && (pending != '0);

    always_comb begin
        pending_next = pending;
        if (do_commit && !do_release) pending_next = pending + PEND_ONE;
        else if (!do_commit && do_release) pending_next = pending - PEND_ONE;
    end

    always_ff @(posedge RX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_idx    <= '0;
            crc         <= CRC32_INIT;
            cur_da      <= '0;
            cur_sa      <= '0;
            cur_lt      <= '0;
            wr_slot     <= '0;
            rd_slot     <= '0;
            pending     <= '0;
            rx_irq      <= 1'b0;
            rx_drop_cnt <= '0;
            rx_mem_wen  <= 1'b0;
            rx_mem_data <= '0;
            rx_mem_addr <= '0;
            for (int s = 0; s < N_SLOTS; s++) begin
                slot_da[s]  <= '0;
                slot_sa[s]  <= '0;
                slot_lt[s]  <= '0;
                slot_len[s] <= '0;
            end
        end else begin
            state      <= state_next;
            rx_mem_wen <= 1'b0;
            if (state == ST_IDLE || state == ST_PREAMBLE) begin
                byte_idx <= '0;
                crc      <= CRC32_INIT;
            end
            if (state == ST_DATA && RX_DV) begin
                rx_mem_wen  <= 1'b1;
                rx_mem_data <= RXD;
                rx_mem_addr <= wr_addr;
                byte_idx    <= byte_idx + 16'd1;
                crc         <= crc_next;
                if (byte_idx < 16'd6) cur_da <= da_full;
                else if (byte_idx < 16'd12) cur_sa <= {cur_sa[39:0], RXD};
                else if (byte_idx < 16'd14) cur_lt <= lt_full;
            end
            if (do_commit) begin
                slot_da[wr_slot]  <= cur_da;
                slot_sa[wr_slot]  <= cur_sa;
                slot_lt[wr_slot]  <= cur_lt;
                slot_len[wr_slot] <= byte_idx;
                wr_slot           <= wr_slot + SLOT_ONE;
            end
            if (do_release) rd_slot <= rd_slot + SLOT_ONE;
            pending <= pending_next;
            rx_irq  <= (pending_next != '0);
            if (drop_inc && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
        end
    end

    assign dst_mac_addr = slot_da[rd_slot];
    assign src_mac_addr = slot_sa[rd_slot];
    assign rx_len_type  = slot_lt[rd_slot];
    assign rx_frame_len = slot_len[rd_slot];
    assign rx_slot_idx  = rd_slot;
endmodule

// File: tb/tb_vthernet_rx_mac_mf.sv
// Directed bench for vthernet_rx_mac_mf: filtering, FCS/length errors, slot ring and reset.
module tb_vthernet_rx_mac_mf;
    localparam logic [47:0] E0 = 48'h020000000010;
    localparam logic [47:0] E1 = 48'h020000000011;
    localparam logic [47:0] E2 = 48'h020000000012;
    localparam logic [47:0] E3 = 48'h020000000013;
    localparam logic [47:0] SA = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] BC = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        RX_CLK = 1'b0;
    logic        rst_n;
    logic [191:0] my_mac_addr;
    logic [3:0]  mac_en;
    logic        promisc, accept_bcast, len_type_en;
    logic [15:0] ethernet_len_type;
    logic [31:0] rx_base_addr;
    logic        RX_DV, RX_ER, rx_slot_release;
    logic [7:0]  RXD;
    logic [47:0] dst_mac_addr, src_mac_addr;
    logic [15:0] rx_len_type, rx_frame_len, rx_drop_cnt;
    logic [1:0]  rx_slot_idx;
    logic        rx_irq, rx_mem_wen;
    logic [7:0]  rx_mem_data;
    logic [31:0] rx_mem_addr;

    vthernet_rx_mac_mf dut (
        .RX_CLK(RX_CLK), .rst_n(rst_n), .my_mac_addr(my_mac_addr), .mac_en(mac_en),
        .promisc(promisc), .accept_bcast(accept_bcast), .ethernet_len_type(ethernet_len_type),
        .len_type_en(len_type_en), .rx_base_addr(rx_base_addr), .RX_DV(RX_DV), .RX_ER(RX_ER),
        .RXD(RXD), .rx_slot_release(rx_slot_release), .dst_mac_addr(dst_mac_addr),
        .src_mac_addr(src_mac_addr), .rx_len_type(rx_len_type), .rx_frame_len(rx_frame_len),
        .rx_slot_idx(rx_slot_idx), .rx_irq(rx_irq), .rx_drop_cnt(rx_drop_cnt),
        .rx_mem_wen(rx_mem_wen), .rx_mem_data(rx_mem_data), .rx_mem_addr(rx_mem_addr)
    );

    always #5 RX_CLK = ~RX_CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  frm [0:2047];
    int          wr_count, data_err;
    logic [31:0] first_addr, last_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge RX_CLK) begin
        if (rx_mem_wen) begin
            if (wr_count == 0) first_addr = rx_mem_addr;
            last_addr = rx_mem_addr;
            wr_count++;
            if (rx_mem_data !== frm[int'((rx_mem_addr - rx_base_addr) & 32'h7FF)]) data_err++;
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // DA/SA/type sent MSB octet first; FCS = ~crc sent LSB octet first
    task automatic build(input int len, input logic [47:0] da, input logic [15:0] lt);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            frm[i]   = da[47-8*i -: 8];
            frm[i+6] = SA[47-8*i -: 8];
        end
        frm[12] = lt[15:8];
        frm[13] = lt[7:0];
        for (int i = 14; i < len - 4; i++) frm[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < len - 4; i++) c = crc_upd(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm[len-4+i] = c[8*i +: 8];
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge RX_CLK); #1;
        RX_DV = dv; RX_ER = er; RXD = d;
    endtask

    task automatic release_slot();
        @(posedge RX_CLK); #1 rx_slot_release = 1'b1;
        @(posedge RX_CLK); #1 rx_slot_release = 1'b0;
    endtask

    task automatic send(input int len, input int err_at, input int rst_at, input logic rel);
        wr_count = 0; data_err = 0; first_addr = '1; last_addr = '1;
        repeat (7) drive(1'b1, 1'b0, 8'b10101010);
        drive(1'b1, 1'b0, 8'b10101011);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_irq", rx_irq, 0);
                check_val("rst_drop", rx_drop_cnt, 0);
                check_val("rst_idx", rx_slot_idx, 0);
                check_val("rst_len", rx_frame_len, 0);
                check_val("rst_dst", dst_mac_addr, 0);
                check_val("rst_src", src_mac_addr, 0);
                check_val("rst_wen", rx_mem_wen, 0);
                check_val("rst_addr", rx_mem_addr, 0);
                RX_DV = 1'b0; RX_ER = 1'b0; RXD = 8'h00;
                @(posedge RX_CLK); #1 rst_n = 1'b1;
                repeat (2) @(posedge RX_CLK);
                #1;
                return;
            end
            drive(1'b1, i == err_at, frm[i]);
        end
        drive(1'b0, 1'b0, 8'h00);
        @(posedge RX_CLK); #1 rx_slot_release = rel;
        @(posedge RX_CLK); #1 rx_slot_release = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; RX_DV = 1'b0; RX_ER = 1'b0; RXD = 8'h00; rx_slot_release = 1'b0;
        my_mac_addr = {E3, E2, E1, E0}; mac_en = 4'b0100; promisc = 1'b0;
        accept_bcast = 1'b0; len_type_en = 1'b0; ethernet_len_type = 16'h0800;
        rx_base_addr = BASE;
        wr_count = 0; data_err = 0; first_addr = '1; last_addr = '1;
        for (int i = 0; i < 2048; i++) frm[i] = 8'h00;
        repeat (3) @(posedge RX_CLK);
        #1;
        check_val("reset_irq", rx_irq, 0);
        check_val("reset_drop", rx_drop_cnt, 0);
        check_val("reset_idx", rx_slot_idx, 0);
        check_val("reset_len", rx_frame_len, 0);
        check_val("reset_wen", rx_mem_wen, 0);
        check_val("reset_addr", rx_mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge RX_CLK);

        build(64, E2, 16'h0800); send(64, -1, -1, 1'b0);
        check_val("good_wr_count", wr_count, 64);
        check_val("good_first_addr", first_addr, BASE);
        check_val("good_last_addr", last_addr, BASE + 63);
        check_val("good_data", data_err, 0);
        check_val("good_irq", rx_irq, 1);
        check_val("good_len", rx_frame_len, 64);
        check_val("good_idx", rx_slot_idx, 0);
        check_val("good_drop", rx_drop_cnt, 0);
        check_val("good_dst", dst_mac_addr, E2);
        check_val("good_src", src_mac_addr, SA);
        check_val("good_lt", rx_len_type, 16'h0800);
        release_slot(); #1;
        check_val("rel1_irq", rx_irq, 0);
        check_val("rel1_idx", rx_slot_idx, 1);

        build(64, E1, 16'h0800); send(64, -1, -1, 1'b0);
        check_val("nomatch_irq", rx_irq, 0);
        check_val("nomatch_drop", rx_drop_cnt, 0);
        promisc = 1'b1; send(64, -1, -1, 1'b0);
        check_val("promisc_irq", rx_irq, 1);
        check_val("promisc_dst", dst_mac_addr, E1);
        check_val("promisc_addr", first_addr, BASE + 2048);
        release_slot(); promisc = 1'b0;

        accept_bcast = 1'b1;
        build(64, BC, 16'h0800); send(64, -1, -1, 1'b0);
        check_val("bcast_irq", rx_irq, 1);
        check_val("bcast_idx", rx_slot_idx, 2);
        check_val("bcast_dst", dst_mac_addr, BC);
        check_val("bcast_addr", first_addr, BASE + 4096);
        release_slot(); accept_bcast = 1'b0;

        len_type_en = 1'b1; ethernet_len_type = 16'h86DD;
        build(64, E2, 16'h0800); send(64, -1, -1, 1'b0);
        check_val("type_bad_irq", rx_irq, 0);
        check_val("type_bad_drop", rx_drop_cnt, 0);
        build(64, E2, 16'h86DD); send(64, -1, -1, 1'b0);
        check_val("type_ok_irq", rx_irq, 1);
        check_val("type_ok_lt", rx_len_type, 16'h86DD);
        check_val("type_ok_idx", rx_slot_idx, 3);
        release_slot(); len_type_en = 1'b0;

        build(64, E2, 16'h0800); frm[30] = frm[30] ^ 8'h01; send(64, -1, -1, 1'b0);
        check_val("fcs_drop", rx_drop_cnt, 1);
        check_val("fcs_irq", rx_irq, 0);
        build(63, E2, 16'h0800); send(63, -1, -1, 1'b0);
        check_val("short_drop", rx_drop_cnt, 2);
        build(1519, E2, 16'h0800); send(1519, -1, -1, 1'b0);
        check_val("long_drop", rx_drop_cnt, 3);
        check_val("long_irq", rx_irq, 0);
        build(64, E2, 16'h0800); send(64, 20, -1, 1'b0);
        check_val("rxer_drop", rx_drop_cnt, 4);
        check_val("rxer_irq", rx_irq, 0);

        build(64, E2, 16'h0800); send(64, -1, -1, 1'b0);
        check_val("pre_rst_irq", rx_irq, 1);
        send(64, -1, 30, 1'b0);

        for (int k = 0; k < 5; k++) begin
            build(64 + k, E2, 16'h0800); send(64 + k, -1, -1, 1'b0);
            if (k < 4) check_val($sformatf("ring_addr%0d", k), first_addr, BASE + 32'(k) * 2048);
        end
        check_val("ring_full_writes", wr_count, 0);
        check_val("ring_full_drop", rx_drop_cnt, 1);
        check_val("ring_full_idx", rx_slot_idx, 0);
        check_val("ring_full_len", rx_frame_len, 64);
        release_slot(); #1;
        check_val("ring_rel_idx", rx_slot_idx, 1);
        check_val("ring_rel_len", rx_frame_len, 65);
        check_val("ring_rel_irq", rx_irq, 1);

        build(70, E2, 16'h0800); send(70, -1, -1, 1'b1);
        check_val("sim_addr_wrap", first_addr, BASE);
        check_val("sim_idx", rx_slot_idx, 2);
        check_val("sim_len", rx_frame_len, 66);
        check_val("sim_irq", rx_irq, 1);
        check_val("sim_drop", rx_drop_cnt, 1);
        release_slot(); #1;
        check_val("drain1_idx", rx_slot_idx, 3);
        check_val("drain1_irq", rx_irq, 1);
        release_slot(); #1;
        check_val("drain2_idx", rx_slot_idx, 0);
        check_val("drain2_len", rx_frame_len, 70);
        check_val("drain2_irq", rx_irq, 1);
        release_slot(); #1;
        check_val("drain3_idx", rx_slot_idx, 1);
        check_val("drain3_irq", rx_irq, 0);
        release_slot(); #1;
        check_val("empty_rel_idx", rx_slot_idx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
